// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store buffer with load forwarding between MEM stage and data memory
module store_buffer #(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         st_valid,
  input  logic [DM_ADDRESS-1:0]        st_addr,
  input  logic [DATA_W-1:0]            st_data,
  input  logic [2:0]                   st_funct3,
  output logic                         st_ready,
  input  logic                         ld_valid,
  input  logic [DM_ADDRESS-1:0]        ld_addr,
  input  logic [2:0]                   ld_funct3,
  output logic                         ld_fwd_valid,
  output logic [DATA_W-1:0]            ld_fwd_data,
  output logic                         ld_stall,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [DM_ADDRESS-1:0]        mem_a,
  output logic [DATA_W-1:0]            mem_wd,
  output logic [2:0]                   mem_funct3,
  output logic [$clog2(DEPTH+1)-1:0]   sb_count,
  output logic                         sb_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  // Entry storage; validity is implied by the head/count window
  logic [DM_ADDRESS-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0]     data_q [DEPTH];
  logic [2:0]            f3_q   [DEPTH];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic                  full, empty;
  logic                  hit;
  logic [DATA_W-1:0]     hit_data;
  logic [2:0]            hit_f3;
  logic [PW-1:0]         idx;
  logic [1:0]            st_size, ld_size;
  logic                  can_fwd, miss;
  logic                  drain, enq;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

  // Walk entries oldest to youngest so the youngest address match wins
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    hit_f3   = '0;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == ld_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
        hit_f3   = f3_q[idx];
      end
    end
  end

  // Access sizes: 0 byte, 1 half, 2 word; a store covers a load when it is at least as wide
  always_comb begin
    case (hit_f3)
      3'b000:  st_size = 2'd0;
      3'b001:  st_size = 2'd1;
      default: st_size = 2'd2;
    endcase
    case (ld_funct3[1:0])
      2'b00:   ld_size = 2'd0;
      2'b01:   ld_size = 2'd1;
      default: ld_size = 2'd2;
    endcase
  end

  assign can_fwd = hit && (st_size >= ld_size);
  assign miss    = !hit;

  // Single memory port: a missing load owns it unless the buffer is full, otherwise the head drains
  always_comb begin
    mem_read     = ld_valid && miss && !full;
    ld_stall     = ld_valid && ((miss && full) || (hit && !can_fwd));
    ld_fwd_valid = ld_valid && can_fwd;
    drain        = !empty && !mem_read;
    mem_write    = drain;
    mem_a        = '0;
    mem_wd       = '0;
    mem_funct3   = '0;
    if (mem_read) begin
      mem_a      = ld_addr;
      mem_funct3 = ld_funct3;
    end else if (drain) begin
      mem_a      = addr_q[head_q];
      mem_wd     = data_q[head_q];
      mem_funct3 = f3_q[head_q];
    end
  end

  // Format forwarded data; ld_funct3[2] selects zero extension for LBU/LHU
  always_comb begin
    ld_fwd_data = '0;
    if (ld_fwd_valid) begin
      case (ld_size)
        2'd0:    ld_fwd_data = ld_funct3[2] ? {{(DATA_W-8){1'b0}}, hit_data[7:0]}
                                            : {{(DATA_W-8){hit_data[7]}}, hit_data[7:0]};
        2'd1:    ld_fwd_data = ld_funct3[2] ? {{(DATA_W-16){1'b0}}, hit_data[15:0]}
                                            : {{(DATA_W-16){hit_data[15]}}, hit_data[15:0]};
        default: ld_fwd_data = hit_data;
      endcase
    end
  end

  assign st_ready = !full || drain;
  assign enq      = st_valid && st_ready;
  assign sb_count = count_q;
  assign sb_empty = empty;

  // Pointer and occupancy next state
  always_comb begin
    head_d  = drain ? head_q + PW'(1) : head_q;
    tail_d  = enq   ? tail_q + PW'(1) : tail_q;
    count_d = count_q;
    if (enq && !drain)      count_d = count_q + CW'(1);
    else if (!enq && drain) count_d = count_q - CW'(1);
  end

  // Pointer/count registers; reset discards every pending store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload written at the tail on accept
  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
      f3_q[tail_q]   <= st_funct3;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer with a queue reference model
module tb_store_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid;
  logic [8:0]  st_addr;
  logic [31:0] st_data;
  logic [2:0]  st_funct3;
  logic        st_ready;
  logic        ld_valid;
  logic [8:0]  ld_addr;
  logic [2:0]  ld_funct3;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;
  logic        ld_stall;
  logic        mem_read;
  logic        mem_write;
  logic [8:0]  mem_a;
  logic [31:0] mem_wd;
  logic [2:0]  mem_funct3;
  logic [2:0]  sb_count;
  logic        sb_empty;

  int errors = 0;
  int checks = 0;

  logic [31:0] tb_mem [512];

  typedef struct {
    logic [8:0]  a;
    logic [31:0] d;
    logic [2:0]  f;
  } ent_t;

  always #5 clk = ~clk;

  store_buffer #(.DM_ADDRESS(9), .DATA_W(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_funct3(st_funct3),
    .st_ready(st_ready),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data), .ld_stall(ld_stall),
    .mem_read(mem_read), .mem_write(mem_write), .mem_a(mem_a), .mem_wd(mem_wd),
    .mem_funct3(mem_funct3), .sb_count(sb_count), .sb_empty(sb_empty)
  );

  // Data memory behaviour: word-indexed, sub-word stores replace the low bytes
  always @(posedge clk) begin
    if (rst_n && mem_write) begin
      case (mem_funct3)
        3'b000:  tb_mem[mem_a][7:0]  = mem_wd[7:0];
        3'b001:  tb_mem[mem_a][15:0] = mem_wd[15:0];
        default: tb_mem[mem_a]       = mem_wd;
      endcase
    end
  end

  function automatic int st_bytes(input logic [2:0] f);
    if (f == 3'b000) return 1;
    if (f == 3'b001) return 2;
    return 4;
  endfunction

  function automatic int ld_bytes(input logic [2:0] f);
    if (f == 3'b000 || f == 3'b100) return 1;
    if (f == 3'b001 || f == 3'b101) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f);
    byte     b;
    shortint h;
    b = w[7:0];
    h = w[15:0];
    case (f)
      3'b000:  return 32'(int'(b));
      3'b001:  return 32'(int'(h));
      3'b100:  return w & 32'h0000_00FF;
      3'b101:  return w & 32'h0000_FFFF;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input ent_t e);
    logic [31:0] mask;
    mask = (st_bytes(e.f) == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * st_bytes(e.f))) - 32'd1);
    return (old & ~mask) | (e.d & mask);
  endfunction

  task automatic drive(input logic sv, input logic [8:0] sa, input logic [31:0] sd,
                       input logic [2:0] sf, input logic lv, input logic [8:0] la,
                       input logic [2:0] lf);
    st_valid = sv; st_addr = sa; st_data = sd; st_funct3 = sf;
    ld_valid = lv; ld_addr = la; ld_funct3 = lf;
  endtask

  task automatic idle_in();
    drive(1'b0, 9'd0, 32'd0, 3'd0, 1'b0, 9'd0, 3'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_in();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_in();
    rst_n = 1'b0;
    #1;
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", sb_empty); end
    checks++; if (st_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", st_ready); end
    checks++; if (sb_count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", sb_count); end
    checks++; if ({mem_write, mem_read, ld_stall, ld_fwd_valid} !== 4'b0)
      begin errors++; $display("FAIL reset_outs got=%b exp=0000", {mem_write, mem_read, ld_stall, ld_fwd_valid}); end
    @(negedge clk);
    rst_n = 1'b1;
    // Build 3 entries while a missing load owns the port
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(1'b1, 9'(40 + i), 32'(1000 + i), 3'b010, 1'b1, 9'd100, 3'b010);
    end
    @(negedge clk);
    idle_in();
    #1;
    checks++; if (sb_count !== 3'd3 || mem_write !== 1'b1)
      begin errors++; $display("FAIL middrain_pre got=%0d/%b exp=3/1", sb_count, mem_write); end
    rst_n = 1'b0;
    #1;
    checks++; if (sb_count !== 3'd0 || mem_write !== 1'b0)
      begin errors++; $display("FAIL middrain_reset got=%0d/%b exp=0/0", sb_count, mem_write); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checks++; if (mem_write !== 1'b0 || sb_empty !== 1'b1)
        begin errors++; $display("FAIL postreset_idle got=%b/%b exp=0/1", mem_write, sb_empty); end
    end
    checks++; if (tb_mem[40] !== 32'd0)
      begin errors++; $display("FAIL discarded_store got=%h exp=0", tb_mem[40]); end
  endtask

  task automatic test_forward_sw();
    @(negedge clk);
    drive(1'b1, 9'd5, 32'hDEADBEEF, 3'b010, 1'b0, 9'd0, 3'd0);
    #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL sw_no_same_cycle got=%b exp=0", mem_write); end
    @(negedge clk);
    drive(1'b0, 9'd0, 32'd0, 3'd0, 1'b1, 9'd5, 3'b010);
    #1;
    checks++; if (ld_fwd_valid !== 1'b1 || ld_fwd_data !== 32'hDEADBEEF)
      begin errors++; $display("FAIL sw_fwd got=%b/%h exp=1/deadbeef", ld_fwd_valid, ld_fwd_data); end
    checks++; if (mem_read !== 1'b0 || mem_write !== 1'b1 || mem_a !== 9'd5 || ld_stall !== 1'b0)
      begin errors++; $display("FAIL sw_drain got=r%b w%b a%0d s%b exp=r0 w1 a5 s0", mem_read, mem_write, mem_a, ld_stall); end
    @(negedge clk);
    idle_in();
    #1;
    checks++; if (tb_mem[5] !== 32'hDEADBEEF || sb_empty !== 1'b1)
      begin errors++; $display("FAIL sw_mem got=%h/%b exp=deadbeef/1", tb_mem[5], sb_empty); end
  endtask

  task automatic test_sub_word();
    @(negedge clk); drive(1'b1, 9'd20, 32'h1111_1111, 3'b010, 1'b1, 9'd100, 3'b010);
    @(negedge clk); drive(1'b1, 9'd21, 32'h2222_2222, 3'b010, 1'b1, 9'd100, 3'b010);
    @(negedge clk); drive(1'b1, 9'd7,  32'h1234_5680, 3'b000, 1'b1, 9'd100, 3'b010);
    @(negedge clk); drive(1'b0, 9'd0, 32'd0, 3'd0, 1'b1, 9'd7, 3'b000);
    #1;
    checks++; if (ld_fwd_valid !== 1'b1 || ld_fwd_data !== 32'hFFFF_FF80)
      begin errors++; $display("FAIL sb_lb got=%b/%h exp=1/ffffff80", ld_fwd_valid, ld_fwd_data); end
    checks++; if (mem_write !== 1'b1 || mem_a !== 9'd20)
      begin errors++; $display("FAIL sb_lb_drain got=%b/%0d exp=1/20", mem_write, mem_a); end
    @(negedge clk); drive(1'b0, 9'd0, 32'd0, 3'd0, 1'b1, 9'd7, 3'b100);
    #1;
    checks++; if (ld_fwd_valid !== 1'b1 || ld_fwd_data !== 32'h0000_0080)
      begin errors++; $display("FAIL sb_lbu got=%b/%h exp=1/00000080", ld_fwd_valid, ld_fwd_data); end
    @(negedge clk); drive(1'b0, 9'd0, 32'd0, 3'd0, 1'b1, 9'd7, 3'b010);
    #1;
    checks++; if (ld_stall !== 1'b1 || ld_fwd_valid !== 1'b0 || ld_fwd_data !== 32'd0 || mem_read !== 1'b0)
      begin errors++; $display("FAIL sb_lw_stall got=s%b f%b d%h r%b exp=s1 f0 d0 r0", ld_stall, ld_fwd_valid, ld_fwd_data, mem_read); end
    checks++; if (mem_write !== 1'b1 || mem_a !== 9'd7 || mem_funct3 !== 3'b000 || mem_wd[7:0] !== 8'h80)
      begin errors++; $display("FAIL sb_lw_drain got=%b/%0d/%b/%h exp=1/7/000/80", mem_write, mem_a, mem_funct3, mem_wd[7:0]); end
    @(negedge clk);
    #1;
    checks++; if (mem_read !== 1'b1 || ld_stall !== 1'b0 || mem_a !== 9'd7 || mem_funct3 !== 3'b010)
      begin errors++; $display("FAIL sb_lw_read got=r%b s%b a%0d f%b exp=r1 s0 a7 f010", mem_read, ld_stall, mem_a, mem_funct3); end
    checks++; if (tb_mem[7] !== 32'h0000_0080)
      begin errors++; $display("FAIL sb_mem got=%h exp=00000080", tb_mem[7]); end
  endtask

  task automatic test_youngest();
    @(negedge clk); drive(1'b1, 9'd3, 32'd1, 3'b010, 1'b1, 9'd100, 3'b010);
    @(negedge clk); drive(1'b1, 9'd3, 32'd2, 3'b010, 1'b1, 9'd100, 3'b010);
    @(negedge clk); drive(1'b0, 9'd0, 32'd0, 3'd0, 1'b1, 9'd3, 3'b010);
    #1;
    checks++; if (ld_fwd_valid !== 1'b1 || ld_fwd_data !== 32'd2)
      begin errors++; $display("FAIL youngest_fwd got=%b/%0d exp=1/2", ld_fwd_valid, ld_fwd_data); end
    checks++; if (mem_write !== 1'b1 || mem_wd !== 32'd1)
      begin errors++; $display("FAIL youngest_order got=%b/%0d exp=1/1", mem_write, mem_wd); end
    @(negedge clk); idle_in();
    @(negedge clk);
    #1;
    checks++; if (tb_mem[3] !== 32'd2 || sb_empty !== 1'b1)
      begin errors++; $display("FAIL youngest_mem got=%0d/%b exp=2/1", tb_mem[3], sb_empty); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(1'b1, 9'(50 + i), 32'(500 + i), 3'b010, 1'b1, 9'd100, 3'b010);
      #1;
      checks++; if (mem_read !== 1'b1 || mem_write !== 1'b0 || sb_count !== 3'(i) || st_ready !== 1'b1)
        begin errors++; $display("FAIL fill_%0d got=r%b w%b c%0d rdy%b exp=r1 w0 c%0d rdy1", i, mem_read, mem_write, sb_count, st_ready, i); end
    end
    @(negedge clk);
    drive(1'b1, 9'd54, 32'd504, 3'b010, 1'b1, 9'd100, 3'b010);
    #1;
    checks++; if (ld_stall !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b1 || mem_a !== 9'd50 || st_ready !== 1'b1 || sb_count !== 3'd4)
      begin errors++; $display("FAIL full_drain got=s%b r%b w%b a%0d rdy%b c%0d exp=s1 r0 w1 a50 rdy1 c4", ld_stall, mem_read, mem_write, mem_a, st_ready, sb_count); end
    @(negedge clk);
    idle_in();
    #1;
    checks++; if (sb_count !== 3'd4 || mem_a !== 9'd51)
      begin errors++; $display("FAIL full_keep got=%0d/%0d exp=4/51", sb_count, mem_a); end
    repeat (4) @(negedge clk);
    #1;
    checks++; if (sb_empty !== 1'b1 || tb_mem[54] !== 32'd504)
      begin errors++; $display("FAIL full_flush got=%b/%0d exp=1/504", sb_empty, tb_mem[54]); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      drive(1'b1, 9'(60 + i), 32'(100 + i), 3'b010, 1'b0, 9'd0, 3'd0);
      #1;
      if (i == 0) begin
        checks++; if (mem_write !== 1'b0 || sb_count !== 3'd0)
          begin errors++; $display("FAIL b2b_first got=%b/%0d exp=0/0", mem_write, sb_count); end
      end else begin
        checks++; if (mem_write !== 1'b1 || mem_a !== 9'(59 + i) || mem_wd !== 32'(99 + i) || sb_count !== 3'd1)
          begin errors++; $display("FAIL b2b_%0d got=w%b a%0d d%0d c%0d exp=w1 a%0d d%0d c1", i, mem_write, mem_a, mem_wd, sb_count, 59 + i, 99 + i); end
      end
    end
    @(negedge clk);
    idle_in();
    #1;
    checks++; if (mem_write !== 1'b1 || mem_a !== 9'd65)
      begin errors++; $display("FAIL b2b_last got=%b/%0d exp=1/65", mem_write, mem_a); end
    @(negedge clk);
    #1;
    checks++; if (sb_empty !== 1'b1 || tb_mem[63] !== 32'd103 || tb_mem[65] !== 32'd105)
      begin errors++; $display("FAIL b2b_mem got=%b/%0d/%0d exp=1/103/105", sb_empty, tb_mem[63], tb_mem[65]); end
  endtask

  task automatic test_random();
    ent_t        q[$];
    ent_t        e, hit_e;
    logic [31:0] model_mem [8];
    logic        e_hit, e_fwd, e_rd, e_stall, e_drain, e_ready, full;
    logic [31:0] e_data;
    do_reset();
    for (int a = 0; a < 8; a++) begin
      tb_mem[a] = 32'd0;
      model_mem[a] = 32'd0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      drive(1'($urandom), 9'($urandom_range(0, 7)), $urandom, 3'($urandom_range(0, 7)),
            ($urandom_range(0, 2) != 0), 9'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      e_hit = 1'b0;
      hit_e = '{a: 9'd0, d: 32'd0, f: 3'd0};
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (q[k].a == ld_addr) begin
          e_hit = 1'b1;
          hit_e = q[k];
          break;
        end
      end
      full    = (q.size() == 4);
      e_fwd   = ld_valid && e_hit && (st_bytes(hit_e.f) >= ld_bytes(ld_funct3));
      e_rd    = ld_valid && !e_hit && !full;
      e_stall = ld_valid && !e_fwd && !e_rd;
      e_drain = (q.size() > 0) && !e_rd;
      e_ready = !full || e_drain;
      e_data  = e_fwd ? fmt_load(hit_e.d, ld_funct3) : 32'd0;
      #1;
      checks++; if ({ld_fwd_valid, ld_stall, mem_read, mem_write, st_ready} !== {e_fwd, e_stall, e_rd, e_drain, e_ready})
        begin errors++; $display("FAIL rnd_ctl cyc=%0d got=%b exp=%b", cyc, {ld_fwd_valid, ld_stall, mem_read, mem_write, st_ready}, {e_fwd, e_stall, e_rd, e_drain, e_ready}); end
      checks++; if (ld_fwd_data !== e_data)
        begin errors++; $display("FAIL rnd_fwd_data cyc=%0d got=%h exp=%h", cyc, ld_fwd_data, e_data); end
      checks++; if (sb_count !== 3'(q.size()) || sb_empty !== (q.size() == 0))
        begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, sb_count, q.size()); end
      if (e_rd) begin
        checks++; if (mem_a !== ld_addr || mem_funct3 !== ld_funct3)
          begin errors++; $display("FAIL rnd_read cyc=%0d got=%0d/%b exp=%0d/%b", cyc, mem_a, mem_funct3, ld_addr, ld_funct3); end
      end
      if (e_drain) begin
        checks++; if (mem_a !== q[0].a || mem_wd !== q[0].d || mem_funct3 !== q[0].f)
          begin errors++; $display("FAIL rnd_drain cyc=%0d got=%0d/%h/%b exp=%0d/%h/%b", cyc, mem_a, mem_wd, mem_funct3, q[0].a, q[0].d, q[0].f); end
      end
      @(posedge clk);
      if (e_drain) begin
        e = q.pop_front();
        model_mem[e.a[2:0]] = merge(model_mem[e.a[2:0]], e);
      end
      if (st_valid && e_ready) q.push_back('{a: st_addr, d: st_data, f: st_funct3});
    end
    while (q.size() > 0) begin
      e = q.pop_front();
      model_mem[e.a[2:0]] = merge(model_mem[e.a[2:0]], e);
    end
    @(negedge clk);
    idle_in();
    repeat (5) @(negedge clk);
    for (int a = 0; a < 8; a++) begin
      checks++; if (tb_mem[a] !== model_mem[a])
        begin errors++; $display("FAIL rnd_mem addr=%0d got=%h exp=%h", a, tb_mem[a], model_mem[a]); end
    end
  endtask

  initial begin
    for (int a = 0; a < 512; a++) tb_mem[a] = 32'd0;
    rst_n = 1'b0;
    idle_in();
    test_reset();
    test_forward_sw();
    test_sub_word();
    test_youngest();
    test_full();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
